// File: rtl/tt_capture.sv
// ---------------------------------------------------------------------------
// tt_capture
//   Sweeps a 3-input combinational device through all eight input
//   combinations. Each index is held for SETTLE_CYCLES clocks before the
//   device output is sampled. The eight samples form an 8-bit truth-table
//   code with code[7-i] = device output at index i.
//
//   Build option: define TT_CAPTURE_VOTE_EN to sample the device on the last
//   three settle cycles of each index and shift in the majority. When it is
//   undefined, a single sample is taken on the last settle cycle. Timing and
//   handshake are the same in both builds.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request a sweep (sampled in IDLE only)
//   abort       cancel a sweep in progress (ignored in FINISH)
//   dut_out     device output, synchronous to clk
//   in1/in2/in3 device stimulus, {in1,in2,in3} = index, in1 is the MSB
//   busy        high while a sweep is active
//   done        one-cycle pulse when a sweep completes
//   code        last complete truth-table code
//   code_valid  code holds a complete capture
// ---------------------------------------------------------------------------
module tt_capture #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic       code_valid
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
`ifdef TT_CAPTURE_VOTE_EN
    localparam logic [CW-1:0] CNT_V0 = CW'(SETTLE_CYCLES - 3);
    localparam logic [CW-1:0] CNT_V1 = CW'(SETTLE_CYCLES - 2);
`endif

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        FINISH
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    // Only the low seven bits of the shift chain need storing: the eighth
    // shift goes straight into code, so the top bit is never read back.
    logic [6:0]    shadow_q;
    logic [7:0]    shadow_d;
    logic          sample_d;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    code_q;
    logic          code_valid_q;

`ifdef TT_CAPTURE_VOTE_EN
    // Samples from the third-to-last and second-to-last settle cycles.
    logic [1:0]    vote_q;

    always_comb begin
        sample_d = (vote_q[0] & vote_q[1]) | (vote_q[0] & dut_out) |
                   (vote_q[1] & dut_out);
    end
`else
    always_comb begin
        sample_d = dut_out;
    end
`endif

    always_comb begin
        shadow_d = {shadow_q, sample_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
`ifdef TT_CAPTURE_VOTE_EN
            vote_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        state_q      <= SETTLE;
                        cnt_q        <= '0;
                        idx_q        <= '0;
                        shadow_q     <= '0;
                        busy_q       <= 1'b1;
                        code_valid_q <= 1'b0;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        // Partial capture is dropped; code keeps its old value.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
`ifdef TT_CAPTURE_VOTE_EN
                        if (cnt_q == CNT_V0) vote_q[0] <= dut_out;
                        if (cnt_q == CNT_V1) vote_q[1] <= dut_out;
`endif
                        if (cnt_q == CNT_LAST) begin
                            cnt_q    <= '0;
                            shadow_q <= shadow_d[6:0];
                            if (idx_q == 3'd7) begin
                                // Outputs for FINISH are registered here so
                                // they appear exactly in the FINISH cycle.
                                state_q      <= FINISH;
                                idx_q        <= '0;
                                busy_q       <= 1'b0;
                                done_q       <= 1'b1;
                                code_q       <= shadow_d;
                                code_valid_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end

                FINISH: begin
                    // abort and start are both ignored here.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign {in1, in2, in3} = idx_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign code            = code_q;
    assign code_valid      = code_valid_q;

endmodule

// File: tb/tb_tt_capture.sv
module tb_tt_capture;

    localparam int S = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       dut_out;
    logic       in1, in2, in3;
    logic       busy;
    logic       done;
    logic [7:0] code;
    logic       code_valid;

    int         tests;
    int         fails;
    int         mode;       // 0: ~in3|in2, 1: tied 1, 2: tied 0
    logic       glitch;
    logic [7:0] last_code;
    logic [7:0] exp_q[$];

    tt_capture #(.SETTLE_CYCLES(S)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .dut_out    (dut_out),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .busy       (busy),
        .done       (done),
        .code       (code),
        .code_valid (code_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device under test model with an optional glitch inverter.
    always_comb begin
        logic m;
        m = 1'b0;
        case (mode)
            0:       m = ~in3 | in2;
            1:       m = 1'b1;
            default: m = 1'b0;
        endcase
        dut_out = m ^ glitch;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full sweep from a negedge. gcyc: cycle with inverted device output;
    // r1/r2: cycles with start re-pulsed; acyc: cycle with abort high.
    task automatic sweep(input logic [7:0] exp, input string tag, input int gcyc,
                         input int r1, input int r2, input int acyc);
        int cyc;
        int nbusy;
        int step_err;
        int hold_err;
        logic [7:0] e;
        nbusy = 0; step_err = 0; hold_err = 0;
        exp_q.push_back(exp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 100) begin
            glitch = (cyc == gcyc);
            abort  = (cyc == acyc);
            start  = (cyc == r1) || (cyc == r2);
            #1;
            if (done) break;
            if (busy) begin
                nbusy++;
                if ({in1, in2, in3} !== 3'((cyc - 1) / S)) step_err++;
            end
            if (code !== last_code || code_valid !== 1'b0) hold_err++;
            @(negedge clk);
            cyc++;
        end
        glitch = 1'b0; abort = 1'b0; start = 1'b0;
        check({tag, " done cycle"}, cyc, 33);
        check({tag, " busy cycles"}, nbusy, 32);
        check({tag, " in stepping errs"}, step_err, 0);
        check({tag, " code/valid hold errs"}, hold_err, 0);
        e = exp_q.pop_front();
        check({tag, " code"}, code, e);
        check({tag, " code_valid"}, code_valid, 1);
        last_code = e;
        @(negedge clk);
        check({tag, " done pulse ends"}, {busy, done, code_valid}, 3'b001);
    endtask

    initial begin
        int n;
        tests = 0; fails = 0;
        mode = 0; glitch = 1'b0; last_code = 8'h00;
        start = 1'b0; abort = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {in1, in2, in3, busy, done, code, code_valid},
              {3'b000, 1'b0, 1'b0, 8'h00, 1'b0});
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 0xBB capture.
        sweep(8'hBB, "bb", 0, 0, 0, 0);

        // Tied high then tied low.
        mode = 1; sweep(8'hFF, "ones", 0, 0, 0, 0);
        mode = 2; sweep(8'h00, "zeros", 0, 0, 0, 0);
        mode = 0; sweep(8'hBB, "bb2", 0, 0, 0, 0);

        // Abort at index 3.
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (12) @(negedge clk);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("abort outputs", {in1, in2, in3, busy, done, code_valid}, 6'b000000);
        check("abort code kept", code, 8'hBB);
        n = 0;
        repeat (40) begin @(negedge clk); if (done || busy) n++; end
        check("abort no done", n, 0);

        // Start re-pulsed mid-sweep is ignored.
        sweep(8'hBB, "repulse", 0, 5, 20, 0);
        n = 0;
        repeat (40) begin @(negedge clk); if (done) n++; end
        check("repulse single done", n, 0);

        // abort during FINISH does not disturb the capture.
        mode = 1; sweep(8'hFF, "abort finish", 0, 0, 0, 33);

        // Reset at index 5.
        mode = 0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (21) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midsweep reset", {in1, in2, in3, busy, done, code, code_valid},
              {3'b000, 1'b0, 1'b0, 8'h00, 1'b0});
        last_code = 8'h00;
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        sweep(8'hBB, "after reset", 0, 0, 0, 0);

        // start and abort together in IDLE.
        start = 1'b1; abort = 1'b1; @(negedge clk); start = 1'b0; abort = 1'b0;
        n = 0;
        repeat (10) begin if (busy) n++; @(negedge clk); end
        check("start+abort idle", n, 0);

        // Glitch on a non-sampled cycle (first settle cycle of index 1).
        sweep(8'hBB, "glitch early", 5, 0, 0, 0);
        // Glitch on the last settle cycle of index 1.
`ifdef TT_CAPTURE_VOTE_EN
        sweep(8'hBB, "glitch last", 8, 0, 0, 0);
`else
        sweep(8'hFB, "glitch last", 8, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
